dcache_2way: RTL

Two-way set-associative, write-through, no-write-allocate data cache in the memory stage of the ARM pipeline, directly upstream of the SRAM controller. Read hits complete in the request cycle. Read misses and every store are forwarded to the SRAM controller. Pipeline stalls on `ready` low.

---
 rtl/dcache_2way.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/dcache_2way.sv
// Two-way set-associative, write-through, no-write-allocate data cache feeding the SRAM controller.
// Define DCACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module dcache_2way (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic        ready,
  output logic        sram_rd,
  output logic        sram_wr,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_ready,
  input  logic [63:0] fill_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int SETS = 64;

  typedef enum logic [1:0] {IDLE, RD_MISS, RD_RESP, WR_THRU} state_t;
  state_t state_reg, state_next;

  logic [SETS-1:0] valid_reg [2];
  logic [SETS-1:0] lru_reg;
  logic [9:0]      tag_mem  [2][SETS];
  logic [63:0]     data_mem [2][SETS];
  logic [31:0]     rd_data_reg;
  logic [31:0]     resp_reg;

  logic [5:0]  index;
  logic [9:0]  tag;
  logic [1:0]  way_hit;
  logic        hit_way;
  logic        victim;
  logic [63:0] hit_block;
  logic [31:0] hit_word;
  logic [31:0] fill_word;
  logic        rd_hit;
  logic        wr_hit;
  logic        fill;
  logic        unused_addr;

  assign index       = addr[8:3];
  assign tag         = addr[18:9];
  assign unused_addr = ^addr[1:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      assign way_hit[gi] = valid_reg[gi][index] && (tag_mem[gi][index] == tag);
    end
  endgenerate

  // At most one way can match, so way 1's match flag doubles as the hit-way index.
  assign hit       = |way_hit;
  assign hit_way   = way_hit[1];
  assign victim    = lru_reg[index];
  assign hit_block = data_mem[hit_way][index];
  assign hit_word  = addr[2] ? hit_block[63:32] : hit_block[31:0];
  assign fill_word = addr[2] ? fill_data[63:32] : fill_data[31:0];

  assign rd_hit = (state_reg == IDLE) && rd_en && !wr_en && hit;
  assign wr_hit = (state_reg == IDLE) && wr_en && hit;
  assign fill   = (state_reg == RD_MISS) && sram_ready;

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    sram_rd    = 1'b0;
    sram_wr    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    rd_data    = rd_data_reg;
    case (state_reg)
      IDLE: begin
        if (wr_en) begin
          state_next = WR_THRU;
        end else if (rd_en) begin
          if (hit) begin
            ready   = 1'b1;
            rd_data = hit_word;
          end else begin
            state_next = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end
      RD_MISS: begin
        sram_rd   = 1'b1;
        sram_addr = {addr[31:3], 3'b000};
        if (sram_ready) state_next = RD_RESP;
      end
      RD_RESP: begin
        ready      = 1'b1;
        rd_data    = resp_reg;
        state_next = IDLE;
      end
      WR_THRU: begin
        sram_wr    = 1'b1;
        sram_addr  = {addr[31:2], 2'b00};
        sram_wdata = wr_data;
        if (sram_ready) begin
          ready      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      valid_reg[0] <= '0;
      valid_reg[1] <= '0;
      lru_reg      <= '0;
      rd_data_reg  <= '0;
      resp_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      rd_data_reg <= rd_data;
      if (fill) begin
        valid_reg[victim][index] <= 1'b1;
        lru_reg[index]           <= ~victim;
        resp_reg                 <= fill_word;
      end
      if (rd_hit || wr_hit) lru_reg[index] <= ~hit_way;
    end
  end

  // Tag/data arrays carry no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && fill) begin
      tag_mem[victim][index]  <= tag;
      data_mem[victim][index] <= fill_data;
    end
    if (rst && wr_hit) begin
      if (addr[2]) data_mem[hit_way][index][63:32] <= wr_data;
      else         data_mem[hit_way][index][31:0]  <= wr_data;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && (hit_count != '1)) hit_count <= hit_count + 32'd1;
      if ((state_reg == IDLE) && (state_next == RD_MISS) && (miss_count != '1))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
